// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the two MW writeback lanes onto a single
// register-file write port. When both lanes write in the same cycle, the
// pair is serialized (top first, then bot) and MW is stalled for one cycle.
// Optional feature macro: WB_SAME_REG_MERGE_EN. When it is defined, a pair
// that targets the same register collapses into a single bot write.
module wb_port_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_top,
    input  logic        we_top,
    input  logic [4:0]  writeReg_top,
    input  logic [31:0] data_top,
    input  logic        valid_bot,
    input  logic        we_bot,
    input  logic [4:0]  writeReg_bot,
    input  logic [31:0] data_bot,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [15:0] serial_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic        req_top;
    logic        req_bot;
    logic        merge;
    logic [4:0]  buf_addr;
    logic [31:0] buf_data;
    logic [15:0] serial_cnt;

    // Writes to r0 are architecturally dead, so they never claim the port.
    assign req_top = valid_top & we_top & (writeReg_top != 5'd0);
    assign req_bot = valid_bot & we_bot & (writeReg_bot != 5'd0);

`ifdef WB_SAME_REG_MERGE_EN
    // The younger write would overwrite the older one anyway.
    assign merge = req_top & req_bot & (writeReg_top == writeReg_bot);
`else
    assign merge = 1'b0;
`endif

    assign stall        = (state == HOLD);
    assign serial_count = serial_cnt;

    // Port arbitration FSM; all port outputs and the bot buffer are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            buf_addr   <= '0;
            buf_data   <= '0;
            serial_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_top && req_bot && !merge) begin
                        rf_we    <= 1'b1;
                        rf_addr  <= writeReg_top;
                        rf_data  <= data_top;
                        buf_addr <= writeReg_bot;
                        buf_data <= data_bot;
                        state    <= HOLD;
                        if (serial_cnt != '1) begin
                            serial_cnt <= serial_cnt + 16'd1;
                        end
                    end else if (req_bot) begin
                        // Covers both the bot-only case and a merged same-register pair.
                        rf_we   <= 1'b1;
                        rf_addr <= writeReg_bot;
                        rf_data <= data_bot;
                    end else if (req_top) begin
                        rf_we   <= 1'b1;
                        rf_addr <= writeReg_top;
                        rf_data <= data_top;
                    end else begin
                        rf_we <= 1'b0;
                    end
                end
                HOLD: begin
                    // Lane inputs are ignored here; MW is held by stall.
                    rf_we   <= 1'b1;
                    rf_addr <= buf_addr;
                    rf_data <= buf_data;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter. Expected values are hand-computed;
// same-register expectations follow the WB_SAME_REG_MERGE_EN build option.
module tb_wb_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        valid_top;
    logic        we_top;
    logic [4:0]  writeReg_top;
    logic [31:0] data_top;
    logic        valid_bot;
    logic        we_bot;
    logic [4:0]  writeReg_bot;
    logic [31:0] data_bot;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [15:0] serial_count;

    int unsigned checks;
    int unsigned errors;
    logic [15:0] exp_cnt;

    wb_port_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_top    (valid_top),
        .we_top       (we_top),
        .writeReg_top (writeReg_top),
        .data_top     (data_top),
        .valid_bot    (valid_bot),
        .we_bot       (we_bot),
        .writeReg_bot (writeReg_bot),
        .data_bot     (data_bot),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .serial_count (serial_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_top(input logic v, input logic w, input logic [4:0] r, input logic [31:0] d);
        valid_top    = v;
        we_top       = w;
        writeReg_top = r;
        data_top     = d;
    endtask

    task automatic set_bot(input logic v, input logic w, input logic [4:0] r, input logic [31:0] d);
        valid_bot    = v;
        we_bot       = w;
        writeReg_bot = r;
        data_bot     = d;
    endtask

    task automatic lanes_idle();
        set_top(1'b0, 1'b0, 5'd0, 32'h0);
        set_bot(1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic st);
        check({tag, "_we"},    {31'd0, rf_we}, {31'd0, we});
        check({tag, "_addr"},  {27'd0, rf_addr}, {27'd0, a});
        check({tag, "_data"},  rf_data, d);
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 16'd0;
        reset_n = 1'b0;
        lanes_idle();

        // Reset state
        tick();
        tick();
        check_port("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        check("reset_cnt", {16'd0, serial_count}, 32'd0);

        // First pair accepted on the first edge after release: top only
        reset_n = 1'b1;
        set_top(1'b1, 1'b1, 5'd5, 32'h11);
        tick();
        check_port("top_only", 1'b1, 5'd5, 32'h11, 1'b0);

        // Nothing requesting: we drops, addr/data hold
        lanes_idle();
        tick();
        check_port("idle_hold", 1'b0, 5'd5, 32'h11, 1'b0);

        // Serialized pair; garbage on lanes during HOLD must be ignored
        set_top(1'b1, 1'b1, 5'd3, 32'hAA);
        set_bot(1'b1, 1'b1, 5'd4, 32'hBB);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check_port("pair_top", 1'b1, 5'd3, 32'hAA, 1'b1);
        set_top(1'b1, 1'b1, 5'd10, 32'hDEAD);
        set_bot(1'b1, 1'b1, 5'd11, 32'hBEEF);
        tick();
        check_port("pair_bot", 1'b1, 5'd4, 32'hBB, 1'b0);
        check("pair_cnt", {16'd0, serial_count}, {16'd0, exp_cnt});
        lanes_idle();
        tick();
        check_port("pair_after", 1'b0, 5'd4, 32'hBB, 1'b0);

        // Same-register pair
        set_top(1'b1, 1'b1, 5'd7, 32'h1);
        set_bot(1'b1, 1'b1, 5'd7, 32'h2);
        tick();
`ifdef WB_SAME_REG_MERGE_EN
        check_port("same_merge", 1'b1, 5'd7, 32'h2, 1'b0);
        lanes_idle();
`else
        exp_cnt = exp_cnt + 16'd1;
        check_port("same_first", 1'b1, 5'd7, 32'h1, 1'b1);
        lanes_idle();
        tick();
        check_port("same_second", 1'b1, 5'd7, 32'h2, 1'b0);
`endif
        check("same_cnt", {16'd0, serial_count}, {16'd0, exp_cnt});
        tick();
        check_port("same_after", 1'b0, 5'd7, 32'h2, 1'b0);

        // r0 on top is dropped; bot write goes through without stall
        set_top(1'b1, 1'b1, 5'd0, 32'h77);
        set_bot(1'b1, 1'b1, 5'd9, 32'h55);
        tick();
        check_port("r0_top", 1'b1, 5'd9, 32'h55, 1'b0);
        check("r0_cnt", {16'd0, serial_count}, {16'd0, exp_cnt});

        // Both lanes r0: no write
        set_top(1'b1, 1'b1, 5'd0, 32'h12);
        set_bot(1'b1, 1'b1, 5'd0, 32'h34);
        tick();
        check_port("r0_both", 1'b0, 5'd9, 32'h55, 1'b0);

        // we low on top, valid low on bot: no write
        set_top(1'b1, 1'b0, 5'd6, 32'h66);
        set_bot(1'b0, 1'b1, 5'd8, 32'h88);
        tick();
        check_port("no_req", 1'b0, 5'd9, 32'h55, 1'b0);

        // Bot-only write with top invalid
        set_top(1'b0, 1'b1, 5'd2, 32'h22);
        set_bot(1'b1, 1'b1, 5'd13, 32'hC0DE);
        tick();
        check_port("bot_only", 1'b1, 5'd13, 32'hC0DE, 1'b0);

        // Reset during HOLD discards the buffered bot write
        set_top(1'b1, 1'b1, 5'd3, 32'hAA);
        set_bot(1'b1, 1'b1, 5'd4, 32'hBB);
        tick();
        check_port("rst_hold_pre", 1'b1, 5'd3, 32'hAA, 1'b1);
        lanes_idle();
        #2;
        reset_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        check_port("rst_hold_async", 1'b0, 5'd0, 32'h0, 1'b0);
        check("rst_hold_cnt", {16'd0, serial_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        set_top(1'b1, 1'b1, 5'd12, 32'h1234);
        tick();
        check_port("rst_release", 1'b1, 5'd12, 32'h1234, 1'b0);
        lanes_idle();
        tick();
        check_port("rst_release_idle", 1'b0, 5'd12, 32'h1234, 1'b0);

        // Saturation: preload the counter near the top, then two serializing pairs
        force dut.serial_cnt = 16'hFFFE;
        #1;
        release dut.serial_cnt;
        #1;
        check("sat_preload", {16'd0, serial_count}, 32'h0000FFFE);
        for (int unsigned i = 0; i < 2; i++) begin
            set_top(1'b1, 1'b1, 5'd20, 32'h100 + i);
            set_bot(1'b1, 1'b1, 5'd21, 32'h200 + i);
            tick();
            check("sat_stall", {31'd0, stall}, 32'd1);
            lanes_idle();
            tick();
            check("sat_bot_addr", {27'd0, rf_addr}, 32'd21);
            check("sat_cnt", {16'd0, serial_count}, 32'h0000FFFF);
        end
        tick();
        check("sat_cnt_hold", {16'd0, serial_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
